// File: rtl/sram_arbiter_if.sv
// Bus bundle for the SRAM arbiter: two requester channels (instruction fetch and data) plus
// the shared memory bus. The slave view is the arbiter; the master view is the surrounding
// cores and memory model.
interface sram_arbiter_if;
  // Instruction-fetch channel
  logic        i_req;
  logic        i_wr;
  logic [1:0]  i_size;
  logic [3:0]  i_wstrb;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;
  // Data channel
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;
  // Shared memory bus
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  // Sticky protocol error
  logic        err_unexp;

  modport slave (
    input  i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output err_unexp
  );

  modport master (
    output i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  err_unexp
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-to-one SRAM bus arbiter with data-channel priority, no preemption once a request is
// presented, and an in-order owner FIFO that routes responses back to the right requester.
// Forwarding is purely combinational; only bookkeeping is registered.
module sram_arbiter #(
  parameter int unsigned OUTST_DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  sram_arbiter_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(OUTST_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StHoldI, StHoldD} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [OUTST_DEPTH-1:0] owner_q, owner_d;
  logic                   err_q;

  logic grant_i, grant_d, push, pop, full, empty;

  assign full  = (cnt_q == CntW'(OUTST_DEPTH));
  assign empty = (cnt_q == '0);

  // Grant selection, bus forwarding and next-state; rst masks all handshakes combinationally.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!full) begin
          if (bus.d_req)      grant_d = 1'b1;
          else if (bus.i_req) grant_i = 1'b1;
        end
      end
      StHoldI: grant_i = 1'b1;
      StHoldD: grant_d = 1'b1;
      default: state_d = StIdle;
    endcase
    if (rst) begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end

    if (state_q == StIdle) begin
      if (grant_d && !bus.m_addr_ok)      state_d = StHoldD;
      else if (grant_i && !bus.m_addr_ok) state_d = StHoldI;
    end else if (bus.m_addr_ok) begin
      state_d = StIdle;
    end

    bus.m_req   = grant_i | grant_d;
    bus.m_wr    = grant_d ? bus.d_wr    : bus.i_wr;
    bus.m_size  = grant_d ? bus.d_size  : bus.i_size;
    bus.m_wstrb = grant_d ? bus.d_wstrb : bus.i_wstrb;
    bus.m_addr  = grant_d ? bus.d_addr  : bus.i_addr;
    bus.m_wdata = grant_d ? bus.d_wdata : bus.i_wdata;

    bus.i_addr_ok = grant_i & bus.m_addr_ok;
    bus.d_addr_ok = grant_d & bus.m_addr_ok;
  end

  // Owner FIFO push/pop and response routing; responses with nothing outstanding are flagged.
  always_comb begin
    push    = bus.m_req & bus.m_addr_ok;
    pop     = bus.m_data_ok & !empty & !rst;
    owner_d = owner_q;
    if (push) owner_d[wptr_q] = grant_d;

    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    bus.i_data_ok = pop & !owner_q[rptr_q];
    bus.d_data_ok = pop &  owner_q[rptr_q];
    bus.i_rdata   = bus.m_rdata;
    bus.d_rdata   = bus.m_rdata;
    bus.err_unexp = err_q;
  end

  // Registered bookkeeping; pointers wrap naturally because OUTST_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (bus.m_data_ok && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (OUTST_DEPTH=2): priority, hold without preemption,
// full-FIFO stall, in-order response routing, unexpected response flag and async reset.
module tb_sram_arbiter;

  logic clk;
  logic rst;
  int   num_checks = 0;
  int   num_errors = 0;

  sram_arbiter_if bus ();

  sram_arbiter #(
    .OUTST_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: inputs change at the falling edge, checks follow 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_wr      = 1'b0;
    bus.i_size    = 2'd2;
    bus.i_wstrb   = 4'h0;
    bus.i_addr    = 32'h0000_0100;
    bus.i_wdata   = 32'h0;
    bus.d_req     = 1'b1;
    bus.d_wr      = 1'b1;
    bus.d_size    = 2'd1;
    bus.d_wstrb   = 4'h3;
    bus.d_addr    = 32'h0000_0200;
    bus.d_wdata   = 32'hCAFE_F00D;
    bus.m_addr_ok = 1'b1;
    bus.m_data_ok = 1'b1;
    bus.m_rdata   = 32'h0;

    // Outputs held quiet while reset is high, even with requests pending
    #1;
    check_eq("rst_m_req", 32'(bus.m_req), 32'd0);
    check_eq("rst_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);
    check_eq("rst_data_ok", {30'd0, bus.i_data_ok, bus.d_data_ok}, 32'd0);
    check_eq("rst_err", 32'(bus.err_unexp), 32'd0);

    // Both request with m_addr_ok=1: data channel first
    @(negedge clk);
    rst           = 1'b0;
    bus.m_data_ok = 1'b0;
    bus.i_req     = 1'b1;
    #1;
    check_eq("prio_m_addr", bus.m_addr, 32'h0000_0200);
    check_eq("prio_d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
    check_eq("prio_i_addr_ok", 32'(bus.i_addr_ok), 32'd0);
    check_eq("prio_m_fields", {bus.m_wdata[15:0], 11'd0, bus.m_wr, bus.m_size, bus.m_wstrb},
             {16'hF00D, 11'd0, 1'b1, 2'd1, 4'h3});
    next_cycle();
    bus.d_req = 1'b0;
    #1;
    check_eq("second_m_addr", bus.m_addr, 32'h0000_0100);
    check_eq("second_i_addr_ok", 32'(bus.i_addr_ok), 32'd1);
    next_cycle();

    // Two outstanding (d then i): a third request is stalled
    bus.i_req     = 1'b0;
    bus.d_req     = 1'b1;
    bus.m_addr_ok = 1'b0;
    #1;
    check_eq("full_m_req", 32'(bus.m_req), 32'd0);
    check_eq("full_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);

    // Response while full and request pending: pop, still no grant
    next_cycle();
    bus.m_addr_ok = 1'b1;
    bus.m_data_ok = 1'b1;
    bus.m_rdata   = 32'h1234_5678;
    #1;
    check_eq("pop_full_m_req", 32'(bus.m_req), 32'd0);
    check_eq("resp1_d_data_ok", 32'(bus.d_data_ok), 32'd1);
    check_eq("resp1_i_data_ok", 32'(bus.i_data_ok), 32'd0);
    check_eq("resp1_d_rdata", bus.d_rdata, 32'h1234_5678);
    check_eq("resp1_i_rdata", bus.i_rdata, 32'h1234_5678);

    // Following cycle: grant d (count 1 -> push), i response pops (count stays 1)
    next_cycle();
    bus.m_rdata = 32'hA5A5_0001;
    #1;
    check_eq("regrant_m_req", 32'(bus.m_req), 32'd1);
    check_eq("regrant_d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
    check_eq("resp2_i_data_ok", 32'(bus.i_data_ok), 32'd1);
    check_eq("resp2_d_data_ok", 32'(bus.d_data_ok), 32'd0);

    // Drain the d entry pushed above
    next_cycle();
    bus.d_req   = 1'b0;
    bus.m_rdata = 32'h0000_BEEF;
    #1;
    check_eq("resp3_d_data_ok", 32'(bus.d_data_ok), 32'd1);
    check_eq("resp3_d_rdata", bus.d_rdata, 32'h0000_BEEF);

    // i granted with m_addr_ok low for 3 cycles; d_req rises in cycle 2; no preemption
    next_cycle();
    bus.m_data_ok = 1'b0;
    bus.m_addr_ok = 1'b0;
    bus.i_req     = 1'b1;
    #1;
    check_eq("hold_c1_m_addr", bus.m_addr, 32'h0000_0100);
    next_cycle();
    bus.d_req = 1'b1;
    #1;
    check_eq("hold_c2_m_addr", bus.m_addr, 32'h0000_0100);
    check_eq("hold_c2_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);
    next_cycle();
    #1;
    check_eq("hold_c3_m_addr", bus.m_addr, 32'h0000_0100);
    next_cycle();
    bus.m_addr_ok = 1'b1;
    #1;
    check_eq("hold_rel_m_addr", bus.m_addr, 32'h0000_0100);
    check_eq("hold_rel_addr_ok", {30'd0, bus.i_addr_ok, bus.d_addr_ok}, 32'd2);
    next_cycle();
    bus.i_req     = 1'b0;
    bus.m_addr_ok = 1'b0;
    #1;
    check_eq("after_hold_m_addr", bus.m_addr, 32'h0000_0200);
    check_eq("after_hold_m_req", 32'(bus.m_req), 32'd1);

    // Now in HOLD_D with one outstanding: asynchronous reset mid-cycle
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_m_req", 32'(bus.m_req), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.d_req = 1'b0;
    bus.m_data_ok = 1'b1;
    bus.m_rdata   = 32'h0BAD_0BAD;
    #1;
    // Outstanding id was discarded by reset
    check_eq("stale_data_ok", {30'd0, bus.i_data_ok, bus.d_data_ok}, 32'd0);
    check_eq("stale_err_pre", 32'(bus.err_unexp), 32'd0);
    next_cycle();
    bus.m_data_ok = 1'b0;
    #1;
    check_eq("stale_err_set", 32'(bus.err_unexp), 32'd1);
    next_cycle();
    #1;
    check_eq("err_sticky", 32'(bus.err_unexp), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("err_async_clr", 32'(bus.err_unexp), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter OUTST_DEPTH, default 2, SHALL set the maximum number of accepted-but-unanswered bus transactions (power of two, 2..8).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high; SHALL force all state to reset values immediately, independent of clk.
REQ-004 i_req, i_wr, i_size[1:0], i_wstrb[3:0], i_addr[31:0], i_wdata[31:0]  input  instruction-fetch requester channel.
REQ-005 i_addr_ok  output 1, i_data_ok  output 1, i_rdata  output 32  instruction-fetch responses.
REQ-006 d_req, d_wr, d_size[1:0], d_wstrb[3:0], d_addr[31:0], d_wdata[31:0]  input  data-memory requester channel (execute stage).
REQ-007 d_addr_ok  output 1, d_data_ok  output 1, d_rdata  output 32  data-memory responses.
REQ-008 m_req, m_wr, m_size[1:0], m_wstrb[3:0], m_addr[31:0], m_wdata[31:0]  output  shared memory bus request.
REQ-009 m_addr_ok  input 1, m_data_ok  input 1, m_rdata  input 32  shared memory bus responses.
REQ-010 err_unexp  output  1  sticky flag: m_data_ok arrived with no outstanding transaction.

Function
REQ-011 Arbiter states SHALL be IDLE, HOLD_I, HOLD_D; reset state IDLE.
REQ-012 In IDLE with outstanding count < OUTST_DEPTH: grant d if d_req, else i if i_req; m_* SHALL be driven combinationally from the granted channel, m_req=1.
REQ-013 In IDLE with count == OUTST_DEPTH: m_req=0, no grant, both *_addr_ok=0.
REQ-014 IDLE -> HOLD_D / HOLD_I when a grant is made and m_addr_ok=0 in that cycle; IDLE stays IDLE when m_addr_ok=1 (handshake completes same cycle).
REQ-015 In HOLD_x: m_req=1, m_* SHALL carry channel x's signals regardless of the other channel's req; transition to IDLE on m_addr_ok=1; no preemption.
REQ-016 Only the currently granted channel's *_addr_ok SHALL assert, equal to m_addr_ok; the other SHALL be 0.
REQ-017 On m_req&&m_addr_ok, the owner ID (0=i, 1=d) SHALL be pushed into an in-order tracking FIFO of depth OUTST_DEPTH; count increments.
REQ-018 On m_data_ok with count>0: pop head; i_data_ok=1 if head=0, d_data_ok=1 if head=1; both *_rdata SHALL equal m_rdata every cycle.
REQ-019 Simultaneous push and pop: count unchanged, FIFO order preserved; full status SHALL come from the registered count (no same-cycle bypass).
REQ-020 m_data_ok with count==0: no *_data_ok, FIFO unchanged, err_unexp set to 1 and held until reset.
REQ-021 FIFO read/write pointers SHALL wrap modulo OUTST_DEPTH; count width log2(OUTST_DEPTH)+1.
REQ-022 Latency: zero added cycles request->bus and response->requester (purely combinational forwarding plus registered bookkeeping).
REQ-023 A requester deasserting *_req while in HOLD_x is a protocol violation; behaviour undefined, no recovery logic required.

Reset
REQ-024 On rst: state=IDLE, count=0, pointers=0, err_unexp=0; m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok SHALL be 0 while rst is high.
REQ-025 Reset asserted mid-transaction SHALL discard all outstanding IDs; responses arriving after reset release SHALL set err_unexp.

Verification
REQ-026 i_req=d_req=1 same cycle, m_addr_ok=1 -> d granted first (m_addr=d_addr, d_addr_ok=1, i_addr_ok=0); i granted next cycle.
REQ-027 i granted, m_addr_ok=0 for 3 cycles, d_req rises in cycle 2 -> m_addr stays i_addr until m_addr_ok, then d granted.
REQ-028 OUTST_DEPTH=2, two accepted reads (d then i), no m_data_ok -> third request sees m_req=0; then m_data_ok rdata=0x1234_5678 -> d_data_ok=1, d_rdata=0x12345678; next m_data_ok -> i_data_ok=1.
REQ-029 Count=2, same cycle m_data_ok and pending request -> pop occurs, no grant that cycle (m_req=0), grant in following cycle.
REQ-030 m_data_ok=1 with count=0 -> both *_data_ok=0, err_unexp=1 and stays 1; assert rst -> err_unexp=0 asynchronously.
REQ-031 rst asserted while HOLD_D with count=1 -> state IDLE, count=0, m_req=0 before next clk edge.
